// File: rtl/mac_array_pipelined.sv
// Multi-lane multiply-accumulate pipeline: product stage, accumulator stage and a
// held output register with round-half-up scaling, saturation and backpressure.
module mac_array_pipelined #(
    parameter int LANES             = 4,
    parameter int A_WIDTH           = 16,
    parameter int B_WIDTH           = 16,
    parameter int ACCUMULATOR_WIDTH = 40,
    parameter int OUTPUT_WIDTH      = 16,
    parameter int OUTPUT_SCALE      = 0
) (
    input  logic                            clk,
    input  logic                            arst_in,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_first,
    input  logic                            in_last,
    input  logic [LANES*A_WIDTH-1:0]        a,
    input  logic signed [B_WIDTH-1:0]       b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*OUTPUT_WIDTH-1:0]   out,
    output logic [LANES-1:0]                out_sat
);

    localparam int RB_SH = (OUTPUT_SCALE > 0) ? OUTPUT_SCALE - 1 : 0;
    localparam logic signed [ACCUMULATOR_WIDTH:0] ROUND_BIAS =
        (OUTPUT_SCALE > 0) ? ((ACCUMULATOR_WIDTH+1)'(1) << RB_SH) : '0;
    localparam logic signed [ACCUMULATOR_WIDTH:0] OUT_MAX =
        {{(ACCUMULATOR_WIDTH+2-OUTPUT_WIDTH){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACCUMULATOR_WIDTH:0] OUT_MIN =
        {{(ACCUMULATOR_WIDTH+2-OUTPUT_WIDTH){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

    // One extra bit of headroom so the rounding bias can never overflow.
    function automatic logic signed [ACCUMULATOR_WIDTH:0] round_shift(
        input logic signed [ACCUMULATOR_WIDTH-1:0] v
    );
        logic signed [ACCUMULATOR_WIDTH:0] ext;
        ext = {v[ACCUMULATOR_WIDTH-1], v} + ROUND_BIAS;
        return ext >>> OUTPUT_SCALE;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [OUTPUT_WIDTH:0] saturate(
        input logic signed [ACCUMULATOR_WIDTH:0] v
    );
        if (v > OUT_MAX) return {1'b1, OUT_MAX[OUTPUT_WIDTH-1:0]};
        if (v < OUT_MIN) return {1'b1, OUT_MIN[OUTPUT_WIDTH-1:0]};
        return {1'b0, v[OUTPUT_WIDTH-1:0]};
    endfunction

    logic                                stall;
    logic signed [ACCUMULATOR_WIDTH-1:0] prod_c   [LANES];
    logic signed [ACCUMULATOR_WIDTH-1:0] acc_next [LANES];
    logic [OUTPUT_WIDTH:0]               post_c   [LANES];
    logic [LANES*OUTPUT_WIDTH-1:0]       res_c;
    logic [LANES-1:0]                    sat_c;

    logic                                vld_p1, first_p1, last_p1;
    logic signed [ACCUMULATOR_WIDTH-1:0] prod_p1 [LANES];
    logic                                vld_p2;
    logic signed [ACCUMULATOR_WIDTH-1:0] acc_p2  [LANES];
    logic                                vld_p3;
    logic [LANES*OUTPUT_WIDTH-1:0]       res_p3;
    logic [LANES-1:0]                    sat_p3;

    // A held, unconsumed result freezes every stage.
    assign stall     = vld_p3 && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = vld_p3;
    assign out       = res_p3;
    assign out_sat   = sat_p3;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_c[i] = ACCUMULATOR_WIDTH'($signed(a[i*A_WIDTH +: A_WIDTH]) * b);
        end
    end

    // ---- stage 1: per-lane product ----
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
            for (int i = 0; i < LANES; i++) prod_p1[i] <= '0;
        end else if (!stall) begin
            vld_p1   <= in_valid;
            first_p1 <= in_valid && in_first;
            last_p1  <= in_valid && in_last;
            for (int i = 0; i < LANES; i++) prod_p1[i] <= prod_c[i];
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            acc_next[i] = first_p1 ? prod_p1[i] : acc_p2[i] + prod_p1[i];
        end
    end

    // ---- stage 2: accumulate; vld_p2 marks a completed accumulation ----
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            vld_p2 <= 1'b0;
            for (int i = 0; i < LANES; i++) acc_p2[i] <= '0;
        end else if (!stall) begin
            vld_p2 <= vld_p1 && last_p1;
            if (vld_p1) begin
                for (int i = 0; i < LANES; i++) acc_p2[i] <= acc_next[i];
            end
        end
    end

    always_comb begin
        res_c = '0;
        sat_c = '0;
        for (int i = 0; i < LANES; i++) begin
            post_c[i] = saturate(round_shift(acc_p2[i]));
            res_c[i*OUTPUT_WIDTH +: OUTPUT_WIDTH] = post_c[i][OUTPUT_WIDTH-1:0];
            sat_c[i] = post_c[i][OUTPUT_WIDTH];
        end
    end

    // ---- stage 3: output register (empty/full), reloads on the consume edge ----
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            vld_p3 <= 1'b0;
            res_p3 <= '0;
            sat_p3 <= '0;
        end else if (!stall) begin
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                res_p3 <= res_c;
                sat_p3 <= sat_c;
            end
        end
    end

endmodule
